// File: rtl/pipe_mux.sv
// pipe_mux: selects one of N data channels and delivers the selected word
// through a two-entry (main + skid) ready/valid buffer. Out-of-range selects
// yield zero data, raise a one-cycle sel_err pulse and bump a saturating
// error counter.
module pipe_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]      select,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err,
    output logic [7:0]           err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] sel_value;
    logic             in_xfer;
    logic             out_xfer;
    logic             sel_bad;
    logic             err_hit;
    logic             load_main;
    logic             load_skid;
    logic             skid_to_main;

    // Channel picked by s; an index past the last channel gives all-zero.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [N*WIDTH-1:0] d,
        input logic [SELW-1:0]    s
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(s) == k) begin
                r = d[k*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // True when the select value does not name an existing channel.
    function automatic logic select_out_of_range(input logic [SELW-1:0] s);
        return (int'(s) >= N);
    endfunction

    // Increment that sticks at the top of the 8-bit range.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign sel_value = pick_channel(in_data, select);
    assign sel_bad   = select_out_of_range(select);
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign err_hit   = in_xfer && !flush && sel_bad;

    // State register; reset and flush both land in EMPTY.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and load decisions for the main/skid pair; flush discards
    // any same-cycle transfer.
    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_nxt    = ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Storage entries; main keeps its contents when the buffer drains so
    // out_data only changes on a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (load_main) begin
                main_data <= sel_value;
            end else if (skid_to_main) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= sel_value;
            end
        end
    end

    // Out-of-range select reporting: one-cycle pulse plus saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            sel_err <= err_hit;
            if (err_hit) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_pipe_mux.sv
// Testbench for pipe_mux: directed scenarios on a 3-channel 32-bit instance
// and a randomised queue-model run on a 5-channel 8-bit instance.
module tb_pipe_mux;

    logic        clk = 1'b0;
    logic        rst;

    logic [95:0] in_data_a;
    logic [1:0]  select_a;
    logic        in_valid_a, in_ready_a, flush_a, out_valid_a, out_ready_a, sel_err_a;
    logic [31:0] out_data_a;
    logic [7:0]  err_cnt_a;

    logic [39:0] in_data_b;
    logic [2:0]  select_b;
    logic        in_valid_b, in_ready_b, flush_b, out_valid_b, out_ready_b, sel_err_b;
    logic [7:0]  out_data_b;
    logic [7:0]  err_cnt_b;

    int checks = 0;
    int fails  = 0;

    pipe_mux #(.WIDTH(32), .N(3), .SELW(2)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .select(select_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .flush(flush_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .sel_err(sel_err_a), .err_cnt(err_cnt_a)
    );

    pipe_mux #(.WIDTH(8), .N(5), .SELW(3)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .select(select_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .sel_err(sel_err_b), .err_cnt(err_cnt_b)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [95:0] mk3(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2);
        return {c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_data_a = '0; select_a = '0; in_valid_a = 0; flush_a = 0; out_ready_a = 0;
        in_data_b = '0; select_b = '0; in_valid_b = 0; flush_b = 0; out_ready_b = 0;
        tick();
        tick();
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid_a); end
        checks++; if (out_data_a !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %0h want 0", out_data_a); end
        checks++; if (sel_err_a !== 1'b0) begin fails++; $display("FAIL reset_sel_err: got %0b want 0", sel_err_a); end
        checks++; if (err_cnt_a !== 8'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_a); end
        checks++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL reset_in_ready_during: got %0b want 0", in_ready_a); end
        checks++; if (out_valid_b !== 1'b0) begin fails++; $display("FAIL reset_out_valid_b: got %0b want 0", out_valid_b); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL reset_in_ready_after: got %0b want 1", in_ready_a); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_vals [3];
        exp_vals[0] = 32'hA; exp_vals[1] = 32'hB; exp_vals[2] = 32'hC;
        in_data_a = mk3(32'hA, 32'hB, 32'hC);
        out_ready_a = 1'b1;
        in_valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            select_a = 2'(i);
            #1;
            checks++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL stream_in_ready[%0d]: got %0b want 1", i, in_ready_a); end
            tick();
            checks++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL stream_out_valid[%0d]: got %0b want 1", i, out_valid_a); end
            checks++; if (out_data_a !== exp_vals[i]) begin fails++; $display("FAIL stream_out_data[%0d]: got %0h want %0h", i, out_data_a, exp_vals[i]); end
        end
        in_valid_a = 1'b0;
        tick();
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL stream_drain: got %0b want 0", out_valid_a); end
    endtask

    task automatic test_backpressure();
        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        select_a = 2'd0;
        in_data_a = mk3(32'h11, 32'h0, 32'h0);
        tick();
        in_data_a = mk3(32'h22, 32'h0, 32'h0);
        tick();
        checks++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL bp_full_in_ready: got %0b want 0", in_ready_a); end
        checks++; if (out_data_a !== 32'h11) begin fails++; $display("FAIL bp_head: got %0h want 11", out_data_a); end
        in_data_a = mk3(32'h33, 32'h0, 32'h0);
        tick();
        checks++; if (out_data_a !== 32'h11) begin fails++; $display("FAIL bp_stable: got %0h want 11", out_data_a); end
        checks++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL bp_stable_valid: got %0b want 1", out_valid_a); end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        checks++; if (out_data_a !== 32'h22) begin fails++; $display("FAIL bp_second: got %0h want 22", out_data_a); end
        checks++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL bp_second_valid: got %0b want 1", out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL bp_in_ready_back: got %0b want 1", in_ready_a); end
        tick();
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL bp_no_dup: got %0b want 0", out_valid_a); end
    endtask

    task automatic test_sel_err();
        out_ready_a = 1'b1;
        in_valid_a = 1'b1;
        select_a = 2'd3;
        in_data_a = mk3(32'h1, 32'h2, 32'h3);
        tick();
        checks++; if (out_valid_a !== 1'b1) begin fails++; $display("FAIL selerr_valid: got %0b want 1", out_valid_a); end
        checks++; if (out_data_a !== 32'h0) begin fails++; $display("FAIL selerr_zero: got %0h want 0", out_data_a); end
        checks++; if (sel_err_a !== 1'b1) begin fails++; $display("FAIL selerr_pulse: got %0b want 1", sel_err_a); end
        checks++; if (err_cnt_a !== 8'd1) begin fails++; $display("FAIL selerr_cnt1: got %0d want 1", err_cnt_a); end
        in_valid_a = 1'b0;
        tick();
        checks++; if (sel_err_a !== 1'b0) begin fails++; $display("FAIL selerr_one_cycle: got %0b want 0", sel_err_a); end
        checks++; if (err_cnt_a !== 8'd1) begin fails++; $display("FAIL selerr_cnt_hold: got %0d want 1", err_cnt_a); end
        in_valid_a = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        checks++; if (err_cnt_a !== 8'd255) begin fails++; $display("FAIL selerr_saturate: got %0d want 255", err_cnt_a); end
        checks++; if (sel_err_a !== 1'b1) begin fails++; $display("FAIL selerr_pulse_sat: got %0b want 1", sel_err_a); end
        in_valid_a = 1'b0;
        tick();
        checks++; if (sel_err_a !== 1'b0) begin fails++; $display("FAIL selerr_idle: got %0b want 0", sel_err_a); end
    endtask

    task automatic test_flush();
        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        select_a = 2'd0;
        in_data_a = mk3(32'h44, 32'h0, 32'h0);
        tick();
        flush_a = 1'b1;
        select_a = 2'd3;
        tick();
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL flush_one_valid: got %0b want 0", out_valid_a); end
        checks++; if (sel_err_a !== 1'b0) begin fails++; $display("FAIL flush_no_selerr: got %0b want 0", sel_err_a); end
        checks++; if (err_cnt_a !== 8'd255) begin fails++; $display("FAIL flush_cnt_kept: got %0d want 255", err_cnt_a); end
        in_valid_a = 1'b1;
        select_a = 2'd0;
        in_data_a = mk3(32'h44, 32'h0, 32'h0);
        tick();
        in_data_a = mk3(32'h55, 32'h0, 32'h0);
        tick();
        checks++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL flush_full: got %0b want 0", in_ready_a); end
        flush_a = 1'b1;
        in_data_a = mk3(32'h66, 32'h0, 32'h0);
        tick();
        flush_a = 1'b0;
        in_valid_a = 1'b0;
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL flush_full_valid: got %0b want 0", out_valid_a); end
        checks++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL flush_in_ready: got %0b want 1", in_ready_a); end
        checks++; if (out_data_a !== 32'h44) begin fails++; $display("FAIL flush_data_retained: got %0h want 44", out_data_a); end
        out_ready_a = 1'b1;
        tick();
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL flush_not_delivered: got %0b want 0", out_valid_a); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (err_cnt_a !== 8'd0) begin fails++; $display("FAIL rmid_clear: got %0d want 0", err_cnt_a); end
        out_ready_a = 1'b1;
        in_valid_a = 1'b1;
        select_a = 2'd3;
        for (int i = 0; i < 5; i++) tick();
        in_valid_a = 1'b0;
        tick();
        out_ready_a = 1'b0;
        in_valid_a = 1'b1;
        select_a = 2'd1;
        in_data_a = mk3(32'h0, 32'h77, 32'h0);
        tick();
        in_data_a = mk3(32'h0, 32'h88, 32'h0);
        tick();
        checks++; if (err_cnt_a !== 8'd5) begin fails++; $display("FAIL rmid_cnt5: got %0d want 5", err_cnt_a); end
        checks++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL rmid_full: got %0b want 0", in_ready_a); end
        rst = 1'b1;
        out_ready_a = 1'b1;
        #1;
        checks++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL rmid_ready_in_rst: got %0b want 0", in_ready_a); end
        tick();
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %0b want 0", out_valid_a); end
        checks++; if (out_data_a !== 32'h0) begin fails++; $display("FAIL rmid_data: got %0h want 0", out_data_a); end
        checks++; if (err_cnt_a !== 8'd0) begin fails++; $display("FAIL rmid_cnt: got %0d want 0", err_cnt_a); end
        checks++; if (in_ready_a !== 1'b0) begin fails++; $display("FAIL rmid_ready_held: got %0b want 0", in_ready_a); end
        rst = 1'b0;
        in_valid_a = 1'b0;
        #1;
        checks++; if (in_ready_a !== 1'b1) begin fails++; $display("FAIL rmid_ready_after: got %0b want 1", in_ready_a); end
        tick();
        checks++; if (out_valid_a !== 1'b0) begin fails++; $display("FAIL rmid_no_delivery: got %0b want 0", out_valid_a); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         exp_cnt;
        logic       exp_sel_err;
        logic       stalled;
        logic [7:0] prev_data;
        logic       in_x, out_x;
        int         s;
        logic [7:0] v;
        exp_cnt = 0; exp_sel_err = 1'b0; stalled = 1'b0; prev_data = 8'h0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            checks++; if (out_valid_b !== (q.size() > 0)) begin fails++; $display("FAIL rand_out_valid@%0d: got %0b want %0b", cyc, out_valid_b, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (out_data_b !== q[0]) begin fails++; $display("FAIL rand_out_data@%0d: got %0h want %0h", cyc, out_data_b, q[0]); end
            end
            if (stalled) begin
                checks++; if (out_data_b !== prev_data) begin fails++; $display("FAIL rand_stall_stable@%0d: got %0h want %0h", cyc, out_data_b, prev_data); end
            end
            checks++; if (sel_err_b !== exp_sel_err) begin fails++; $display("FAIL rand_sel_err@%0d: got %0b want %0b", cyc, sel_err_b, exp_sel_err); end
            checks++; if (err_cnt_b !== 8'(exp_cnt)) begin fails++; $display("FAIL rand_err_cnt@%0d: got %0d want %0d", cyc, err_cnt_b, exp_cnt); end

            in_valid_b  = (cyc < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
            out_ready_b = (cyc < 1000) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) != 0);
            select_b    = 3'($urandom_range(0, 7));
            in_data_b   = {8'($urandom), 32'($urandom)};
            flush_b     = ($urandom_range(0, 49) == 0);
            #1;
            checks++; if (in_ready_b !== (q.size() < 2)) begin fails++; $display("FAIL rand_in_ready@%0d: got %0b want %0b", cyc, in_ready_b, q.size() < 2); end

            stalled = (q.size() > 0) && !out_ready_b && !flush_b;
            if (q.size() > 0) prev_data = q[0];
            if (flush_b) begin
                q.delete();
                exp_sel_err = 1'b0;
            end else begin
                in_x  = in_valid_b && (q.size() < 2);
                out_x = (q.size() > 0) && out_ready_b;
                s = int'(select_b);
                if (out_x) void'(q.pop_front());
                if (in_x) begin
                    v = 8'h00;
                    if (s < 5) v = in_data_b[s*8 +: 8];
                    q.push_back(v);
                end
                exp_sel_err = in_x && (s >= 5);
                if (exp_sel_err && exp_cnt < 255) exp_cnt++;
            end
            tick();
        end
        in_valid_b = 1'b0;
        flush_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_sel_err();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each data channel.
REQ-002 SHALL have parameter N, default 3: number of input channels, legal range 2..16.
REQ-003 SHALL have parameter SELW, default 2: select width, equal to ceil(log2(N)) and at least 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  N*WIDTH  flattened channels; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 SHALL have port select  input  SELW  channel index, sampled together with in_data.
REQ-008 SHALL have port in_valid  input  1  producer offers in_data/select.
REQ-009 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-010 SHALL have port flush  input  1  discard all buffered entries.
REQ-011 SHALL have port out_data  output  WIDTH  selected, registered data.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-014 SHALL have port sel_err  output  1  registered pulse for an out-of-range select.
REQ-015 SHALL have port err_cnt  output  8  saturating count of out-of-range selects.

Function
REQ-016 SHALL treat an input transfer as in_valid AND in_ready in the same cycle, and an output transfer as out_valid AND out_ready in the same cycle.
REQ-017 SHALL compute the selected value as channel[select] when select < N; otherwise as all-zero.
REQ-018 SHALL store the selected value, not the raw channels; latency is 1 cycle from input transfer to out_valid, and throughput is 1 transfer per cycle.
REQ-019 SHALL hold two storage entries, main and skid, with state EMPTY (none), ONE (main) or FULL (main+skid); out_data/out_valid SHALL reflect main.
REQ-020 SHALL drive in_ready = (state != FULL) AND NOT rst, combinationally.
REQ-021 SHALL transition from EMPTY to ONE on an input transfer, loading main; otherwise it stays EMPTY.
REQ-022 SHALL behave as follows in ONE:
- input and output transfer: main loads the new value, stays ONE.
- input only: skid loads the new value, goes to FULL.
- output only: goes to EMPTY.
- neither: holds.
REQ-023 SHALL, in FULL with an output transfer, copy skid to main and go to ONE; without an output transfer it holds; no input transfer is possible in FULL.
REQ-024 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-025 SHALL make flush=1 dominate: next state is EMPTY and out_valid becomes 0; any same-cycle input or output transfer is discarded; err_cnt is unaffected.
REQ-026 SHALL, on an input transfer with select >= N (and no flush), set sel_err=1 for exactly the next cycle and increment err_cnt; otherwise sel_err=0 next cycle.
REQ-027 SHALL saturate err_cnt at 255; further errors still pulse sel_err.
REQ-028 SHALL retain out_data contents when going to EMPTY; only out_valid qualifies it.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set state EMPTY, out_valid=0, out_data=0, skid=0, sel_err=0 and err_cnt=0.
REQ-030 SHALL abort an in-flight transfer when reset is asserted mid-operation; buffered entries are lost and no output transfer completes in that cycle.
REQ-031 SHALL give rst priority over flush and all transfers; in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 SHALL cover streaming: N=3, out_ready=1, inputs (sel0=0xA, sel1=0xB, sel2=0xC) on consecutive cycles -> out_data 0xA, 0xB, 0xC on the following consecutive cycles, with in_ready held at 1.
REQ-033 SHALL cover backpressure: out_ready=0, two inputs 0x11 then 0x22 -> state FULL, in_ready=0, out_data stable at 0x11; raise out_ready -> 0x11, then 0x22, with no loss or duplication.
REQ-034 SHALL cover an out-of-range select: N=3, select=3 with in_valid -> out_data=0 with out_valid=1 next cycle, sel_err pulses 1 cycle, err_cnt=1; 300 such inputs -> err_cnt=255.
REQ-035 SHALL cover flush: in FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, state EMPTY, in_ready=1, and the new input is not delivered.
REQ-036 SHALL cover reset mid-operation: in FULL with err_cnt=5, rst=1 for one cycle -> out_valid=0, out_data=0, err_cnt=0, in_ready=0 during rst and 1 on the next cycle.
REQ-037 SHALL cover randomised valid/ready with N=5, WIDTH=8 -> output sequence equals the scoreboard of selected values, and no data change while stalled.
